sti_dac_p: RTL and testbench
============================

Name: sti_dac_p

Overview:
Parametrised serial-transmit-interface plus data-arrangement controller. It accepts parallel words with a length/alignment control, and shifts each resulting frame out serially (MSB- or LSB-first). In parallel it packs the transmitted bits into PIX_W-bit pixels and writes them to a DEPTH-entry pixel memory. On an end command it zero-fills the remaining memory and raises a finish flag. It sits between the host parallel bus and the downstream serial sink and pixel RAM.

Parameters:
IN_W, 16, parallel input data width; must be a multiple of PIX_W.
PIX_W, 8, pixel width; also the frame length granule.
LEN_W, 2, width of pi_length; frame length F = PIX_W*(pi_length+1), so F_MAX = PIX_W*2^LEN_W.
ADDR_W, 8, pixel address width.
DEPTH, 256, pixel memory entries; DEPTH <= 2^ADDR_W.

Ports:
clk  in  1  clock; all logic on rising edge.
reset  in  1  synchronous, active-low reset.
load  in  1  command strobe; accepted only when pi_ready=1.
pi_ready  out  1  high when the block can accept a command.
pi_data  in  IN_W  parallel data.
pi_length  in  LEN_W  frame length code.
pi_fill  in  1  when F>IN_W: 1 = data at MSB side, 0 = data at LSB side; other bits zero.
pi_low  in  1  when F<IN_W: 1 = take the top F bits of pi_data, 0 = take the bottom F bits.
pi_msb  in  1  1 = frame is sent MSB-first, 0 = LSB-first.
pi_end  in  1  end command; qualified by load.
so_data  out  1  serial bit.
so_valid  out  1  so_data is valid.
pixel_wr  out  1  one-cycle pixel write strobe.
pixel_addr  out  ADDR_W  write address.
pixel_dataout  out  PIX_W  write data.
pixel_finish  out  1  memory complete; sticky until reset.

Behaviour:
- Reset (reset=0 at a clk edge) sets: state IDLE, pi_ready=1, so_data=0, so_valid=0, pixel_wr=0, pixel_addr=0, pixel_dataout=0, pixel_finish=0, write pointer=0. Reset mid-frame or mid-fill aborts the operation immediately, with no further writes.
- States:
  - IDLE: pi_ready=1.
  - SHIFT: transmitting a frame.
  - FILL: zero-fill.
  - DONE: pi_ready=0 forever.
- IDLE, load=1 and pi_end=0: latch the frame, then go to SHIFT.
  - Frame build: F<IN_W uses pi_low selection; F==IN_W uses pi_data; F>IN_W uses pi_fill placement, zero-padded.
- IDLE, load=1 and pi_end=1: go to FILL. pi_data is ignored; pi_end takes priority.
- Load is ignored when pi_ready=0.
- SHIFT timing:
  - Load accepted at edge T gives the first bit with so_valid=1 after edge T+1, then F consecutive bits.
  - Bit k (k=0..F-1) is frame[F-1-k] when pi_msb=1, else frame[k]. pi_msb is latched with the load.
  - After the last bit: so_valid=0 and return to IDLE, so there is at least one idle cycle between frames.
- Pixel packing:
  - Within each PIX_W-bit group of the serial stream, the first bit sent lands in pixel bit PIX_W-1.
  - The cycle after a group's last bit is on so_data, pixel_wr=1 for one cycle with pixel_dataout = the group and pixel_addr = write pointer. The pointer increments afterwards.
  - A frame produces F/PIX_W writes; the final write may overlap the first IDLE cycle.
  - pixel_addr holds its last value when pixel_wr=0.
- FILL:
  - One write per cycle, pixel_dataout=0, addresses from the pointer through DEPTH-1.
  - The cycle after the last fill write, pixel_finish=1 and the state goes to DONE.
  - If the pointer already equals DEPTH, there are no writes and finish is asserted on the next cycle.
- Capacity: when the pointer reaches DEPTH through frame writes, pixel_finish=1 after the last write and the state goes to DONE. Any remaining bits of the current frame still shift out, but their pixel writes are suppressed. No address wrap-around.
- so_valid and pixel_wr may be high in the same cycle. pixel_wr is never asserted in IDLE except for the trailing write of a frame.
- Counters: bit counter sized clog2(F_MAX); pointer sized ADDR_W+1 so that DEPTH is representable.

Test Plan:
- Reset then load with pi_length=1, pi_data=16'hA53C, pi_msb=1 -> 16 bits 1010010100111100 with so_valid high for 16 cycles starting T+1; writes A5@0 and 3C@1; pi_ready low during SHIFT.
- pi_length=0, pi_data=16'hA53C, pi_low=1, pi_msb=0 -> bits of 8'hA5 sent LSB-first (1,0,1,0,0,1,0,1); one write of 8'hA5 (first bit sent = pixel MSB).
- pi_length=3, pi_fill=1, pi_data=16'h1234, pi_msb=1 -> 32 bits of 32'h12340000; writes 12,34,00,00 at consecutive addresses.
- After 3 pixels written, load with pi_end=1 and pi_data=16'hFFFF -> zero writes to addresses 3..255 on consecutive cycles, pixel_finish=1 one cycle after addr 255, pi_ready stays 0, later loads ignored.
- Fill DEPTH pixels using 32-bit frames with no pi_end -> pixel_finish after address 255, no wrap to 0, extra loads ignored.
- Assert reset=0 mid-frame (bit 5) -> next cycle so_valid=0, pixel_wr=0, pixel_addr=0, pi_ready=1; a subsequent frame writes from address 0.

Source files
------------

// File: rtl/sti_dac_p.sv
// Serial transmit interface with pixel packing: shifts framed parallel words out bit-serially
// while assembling the sent bits into PIX_W-bit pixels written to a DEPTH-entry pixel memory.
`timescale 1ns/1ps
module sti_dac_p #(
    parameter int IN_W   = 16,
    parameter int PIX_W  = 8,
    parameter int LEN_W  = 2,
    parameter int ADDR_W = 8,
    parameter int DEPTH  = 256
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    output logic              pi_ready,
    input  logic [IN_W-1:0]   pi_data,
    input  logic [LEN_W-1:0]  pi_length,
    input  logic              pi_fill,
    input  logic              pi_low,
    input  logic              pi_msb,
    input  logic              pi_end,
    output logic              so_data,
    output logic              so_valid,
    output logic              pixel_wr,
    output logic [ADDR_W-1:0] pixel_addr,
    output logic [PIX_W-1:0]  pixel_dataout,
    output logic              pixel_finish
);

    localparam int F_MAX = PIX_W << LEN_W;
    localparam int WW    = (F_MAX > IN_W) ? F_MAX : IN_W;
    localparam int CNT_W = (F_MAX > 1) ? $clog2(F_MAX) : 1;
    localparam int GRP_W = (PIX_W > 1) ? $clog2(PIX_W) : 1;
    localparam int PTR_W = ADDR_W + 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_FILL,
        ST_DONE
    } state_t;

    state_t r_state;
    state_t w_state_next;

    logic [F_MAX-1:0]  r_shreg;
    logic              r_msb;
    logic [LEN_W-1:0]  r_len;
    logic [CNT_W-1:0]  r_bit_cnt;
    logic [GRP_W-1:0]  r_grp_cnt;
    logic              r_tail;
    logic [PIX_W-1:0]  r_pix_acc;
    logic              r_grp_done;
    logic [PTR_W-1:0]  r_ptr;
    logic              r_so_data;
    logic              r_so_valid;
    logic              r_pix_wr;
    logic [ADDR_W-1:0] r_pix_addr;
    logic [PIX_W-1:0]  r_pix_data;
    logic              r_finish;

    logic [WW-1:0]     w_data_ext;
    logic [WW-1:0]     w_frame;
    logic [F_MAX-1:0]  w_shreg_init;
    int                w_f;
    logic              w_full;
    logic              w_accept;
    logic              w_bit;
    logic [CNT_W-1:0]  w_last_idx;

    assign w_full     = (r_ptr == PTR_W'(DEPTH));
    assign pi_ready   = (r_state == ST_IDLE) && !w_full;
    assign w_accept   = load && pi_ready;
    assign w_bit      = r_msb ? r_shreg[F_MAX-1] : r_shreg[0];
    assign w_last_idx = CNT_W'(PIX_W * (int'(r_len) + 1) - 1);

    // Frame is built right-aligned in [F-1:0]; MSB-first frames are then left-aligned
    // so both directions shift out of a fixed end of the register.
    always_comb begin
        w_data_ext = WW'(pi_data);
        w_f        = PIX_W * (int'(pi_length) + 1);
        w_frame    = w_data_ext;
        if (w_f < IN_W) begin
            if (pi_low) w_frame = w_data_ext >> (IN_W - w_f);
            else        w_frame = w_data_ext & ~({WW{1'b1}} << w_f);
        end else if (w_f > IN_W) begin
            if (pi_fill) w_frame = w_data_ext << (w_f - IN_W);
        end
        if (pi_msb) w_shreg_init = F_MAX'(w_frame << (F_MAX - w_f));
        else        w_shreg_init = F_MAX'(w_frame);
    end

    always_ff @(posedge clk) begin
        if (!reset) r_state <= ST_IDLE;
        else        r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_full)    w_state_next = ST_DONE;
                else if (load) w_state_next = pi_end ? ST_FILL : ST_SHIFT;
            end
            ST_SHIFT: begin
                if (r_tail) w_state_next = w_full ? ST_DONE : ST_IDLE;
            end
            ST_FILL: begin
                if (w_full) w_state_next = ST_DONE;
            end
            default: w_state_next = ST_DONE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_shreg    <= '0;
            r_msb      <= 1'b0;
            r_len      <= '0;
            r_bit_cnt  <= '0;
            r_grp_cnt  <= '0;
            r_tail     <= 1'b0;
            r_pix_acc  <= '0;
            r_grp_done <= 1'b0;
            r_ptr      <= '0;
            r_so_data  <= 1'b0;
            r_so_valid <= 1'b0;
            r_pix_wr   <= 1'b0;
            r_pix_addr <= '0;
            r_pix_data <= '0;
            r_finish   <= 1'b0;
        end else begin
            r_so_valid <= 1'b0;
            r_grp_done <= 1'b0;
            r_pix_wr   <= 1'b0;
            if (w_full) r_finish <= 1'b1;

            // A completed group is written one cycle after its last bit left; once the
            // memory is full further groups are dropped.
            if (r_grp_done && !w_full) begin
                r_pix_wr   <= 1'b1;
                r_pix_addr <= r_ptr[ADDR_W-1:0];
                r_pix_data <= r_pix_acc;
                r_ptr      <= r_ptr + 1'b1;
            end

            case (r_state)
                ST_IDLE: begin
                    if (w_accept && !pi_end) begin
                        r_shreg   <= w_shreg_init;
                        r_msb     <= pi_msb;
                        r_len     <= pi_length;
                        r_bit_cnt <= '0;
                        r_grp_cnt <= '0;
                        r_tail    <= 1'b0;
                    end
                end
                ST_SHIFT: begin
                    if (!r_tail) begin
                        r_so_valid <= 1'b1;
                        r_so_data  <= w_bit;
                        r_shreg    <= r_msb ? (r_shreg << 1) : (r_shreg >> 1);
                        r_pix_acc  <= (r_pix_acc << 1) | PIX_W'(w_bit);
                        if (r_grp_cnt == GRP_W'(PIX_W - 1)) begin
                            r_grp_done <= 1'b1;
                            r_grp_cnt  <= '0;
                        end else begin
                            r_grp_cnt <= r_grp_cnt + 1'b1;
                        end
                        if (r_bit_cnt == w_last_idx) r_tail <= 1'b1;
                        else                         r_bit_cnt <= r_bit_cnt + 1'b1;
                    end
                end
                ST_FILL: begin
                    if (!w_full) begin
                        r_pix_wr   <= 1'b1;
                        r_pix_addr <= r_ptr[ADDR_W-1:0];
                        r_pix_data <= '0;
                        r_ptr      <= r_ptr + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign so_data       = r_so_data;
    assign so_valid      = r_so_valid;
    assign pixel_wr      = r_pix_wr;
    assign pixel_addr    = r_pix_addr;
    assign pixel_dataout = r_pix_data;
    assign pixel_finish  = r_finish;

endmodule

// File: tb/tb_sti_dac_p.sv
// Scoreboard bench for sti_dac_p: driver pushes model-predicted serial bits and pixel writes,
// a negedge monitor pops and compares whenever the DUT presents them.
`timescale 1ns/1ps
module tb_sti_dac_p;
    localparam int IN_W = 16, PIX_W = 8, LEN_W = 2, ADDR_W = 8, DEPTH = 256;

    logic clk = 1'b0;
    logic reset, load, pi_ready, pi_fill, pi_low, pi_msb, pi_end;
    logic [IN_W-1:0] pi_data;
    logic [LEN_W-1:0] pi_length;
    logic so_data, so_valid, pixel_wr, pixel_finish;
    logic [ADDR_W-1:0] pixel_addr;
    logic [PIX_W-1:0] pixel_dataout;

    sti_dac_p #(.IN_W(IN_W), .PIX_W(PIX_W), .LEN_W(LEN_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .load(load), .pi_ready(pi_ready), .pi_data(pi_data),
        .pi_length(pi_length), .pi_fill(pi_fill), .pi_low(pi_low), .pi_msb(pi_msb),
        .pi_end(pi_end), .so_data(so_data), .so_valid(so_valid), .pixel_wr(pixel_wr),
        .pixel_addr(pixel_addr), .pixel_dataout(pixel_dataout), .pixel_finish(pixel_finish)
    );

    always #5 clk = ~clk;

    int total = 0, bad = 0, cyc = 0;
    bit exp_bits[$];
    int exp_wa[$];
    int exp_wd[$];
    int mptr = 0;
    bit fin_seen = 0;
    int fin_cyc = 0;
    int wr_last_cyc = -100;

    always @(posedge clk) cyc++;

    task automatic chk(input string name, input longint got, input longint want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", name, got, want);
        end
    endtask

    // Monitor: every valid serial bit and every pixel write must match the queue head.
    always @(negedge clk) begin
        if (reset) begin
            if (so_valid) begin
                if (exp_bits.size() == 0) begin
                    total++; bad++;
                    $display("FAIL serial_unexpected got=%0b want=none", so_data);
                end else begin
                    chk("serial_bit", so_data, exp_bits.pop_front());
                end
            end
            if (pixel_wr) begin
                if (exp_wa.size() == 0) begin
                    total++; bad++;
                    $display("FAIL pixel_unexpected got=%0h@%0d want=none", pixel_dataout, pixel_addr);
                end else begin
                    chk("pixel_addr", pixel_addr, exp_wa.pop_front());
                    chk("pixel_data", pixel_dataout, exp_wd.pop_front());
                end
                if (pixel_addr == ADDR_W'(DEPTH - 1)) wr_last_cyc = cyc;
            end
            if (pixel_finish && !fin_seen) begin
                fin_seen = 1;
                fin_cyc  = cyc;
            end
        end
    end

    // Reference model: frame as a plain integer, bits in send order, pixels first-bit-high.
    task automatic model_frame(input logic [15:0] d, input int len, input bit fill, low, msb);
        int f;
        longint fr, dd, one;
        int pix;
        bit b;
        f = PIX_W * (len + 1);
        dd = longint'(d);
        one = 1;
        if (f < IN_W)      fr = low ? (dd >> (IN_W - f)) : (dd % (one << f));
        else if (f > IN_W) fr = fill ? (dd << (f - IN_W)) : dd;
        else               fr = dd;
        pix = 0;
        for (int k = 0; k < f; k++) begin
            b = msb ? fr[f-1-k] : fr[k];
            exp_bits.push_back(b);
            pix = pix * 2 + int'(b);
            if (k % PIX_W == PIX_W - 1) begin
                if (mptr < DEPTH) begin
                    exp_wa.push_back(mptr);
                    exp_wd.push_back(pix);
                end
                mptr++;
                pix = 0;
            end
        end
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!pi_ready && n < 500) begin
            @(negedge clk);
            n++;
        end
        chk("ready_before_load", pi_ready, 1);
    endtask

    task automatic send(input logic [15:0] d, input int len, input bit fill, low, msb);
        int f, gaps;
        f = PIX_W * (len + 1);
        gaps = 0;
        wait_ready();
        if (!pi_ready) return;
        pi_data = d; pi_length = len[1:0]; pi_fill = fill; pi_low = low; pi_msb = msb;
        pi_end = 0; load = 1;
        model_frame(d, len, fill, low, msb);
        @(posedge clk);
        @(negedge clk);
        load = 0;
        chk("ready_in_shift", pi_ready, 0);
        chk("valid_before_first", so_valid, 0);
        for (int k = 0; k < f; k++) begin
            @(negedge clk);
            if (!so_valid) gaps++;
        end
        chk("valid_run_gaps", gaps, 0);
        @(negedge clk);
        chk("valid_after_frame", so_valid, 0);
    endtask

    task automatic send_end();
        wait_ready();
        if (!pi_ready) return;
        pi_data = 16'hFFFF; pi_end = 1; load = 1;
        for (int a = mptr; a < DEPTH; a++) begin
            exp_wa.push_back(a);
            exp_wd.push_back(0);
        end
        mptr = DEPTH;
        @(posedge clk);
        @(negedge clk);
        load = 0; pi_end = 0;
    endtask

    task automatic wait_finish(input string name);
        int n = 0;
        while (!fin_seen && n < 600) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        chk({name, "_seen"}, fin_seen, 1);
        if (fin_seen) chk({name, "_latency"}, fin_cyc - wr_last_cyc, 1);
        chk({name, "_level"}, pixel_finish, 1);
        chk({name, "_ready"}, pi_ready, 0);
    endtask

    task automatic try_load();
        chk("ready_low_done", pi_ready, 0);
        pi_data = 16'($urandom); pi_length = 2'($urandom); pi_end = 1'($urandom); load = 1;
        @(posedge clk);
        @(negedge clk);
        load = 0; pi_end = 0;
        repeat (40) @(negedge clk);
        chk("ready_stays_low", pi_ready, 0);
        chk("finish_sticky", pixel_finish, 1);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 0; load = 0; pi_end = 0;
        repeat (2) @(posedge clk);
        exp_bits.delete(); exp_wa.delete(); exp_wd.delete();
        mptr = 0; fin_seen = 0; wr_last_cyc = -100;
        @(negedge clk);
        reset = 1;
        @(negedge clk);
    endtask

    task automatic send_rand(input int len);
        send(16'($urandom), len, 1'($urandom), 1'($urandom), 1'($urandom));
    endtask

    initial begin
        reset = 0; load = 0; pi_data = '0; pi_length = '0;
        pi_fill = 0; pi_low = 0; pi_msb = 0; pi_end = 0;
        do_reset();
        chk("rst_ready", pi_ready, 1);
        chk("rst_valid", so_valid, 0);
        chk("rst_so_data", so_data, 0);
        chk("rst_wr", pixel_wr, 0);
        chk("rst_addr", pixel_addr, 0);
        chk("rst_dout", pixel_dataout, 0);
        chk("rst_finish", pixel_finish, 0);

        send(16'hA53C, 1, 0, 0, 1);
        send(16'hA53C, 0, 0, 1, 0);
        send(16'h1234, 3, 1, 0, 1);
        for (int i = 0; i < 6; i++) send_rand(int'($urandom_range(0, 3)));

        // Abort a frame partway through with reset.
        wait_ready();
        pi_data = 16'($urandom); pi_length = 2'd3; pi_msb = 1; pi_end = 0; load = 1;
        model_frame(pi_data, 3, pi_fill, pi_low, 1);
        @(posedge clk);
        @(negedge clk);
        load = 0;
        repeat (6) @(negedge clk);
        reset = 0;
        @(posedge clk);
        exp_bits.delete(); exp_wa.delete(); exp_wd.delete();
        mptr = 0;
        @(negedge clk);
        chk("abort_valid", so_valid, 0);
        chk("abort_wr", pixel_wr, 0);
        chk("abort_addr", pixel_addr, 0);
        chk("abort_ready", pi_ready, 1);
        reset = 1;
        @(negedge clk);

        send(16'hA53C, 1, 0, 0, 1);
        send(16'hA53C, 0, 0, 1, 0);
        send_end();
        wait_finish("fill_finish");
        try_load();

        do_reset();
        for (int i = 0; i < DEPTH / 4; i++) send_rand(3);
        wait_finish("cap_finish");
        try_load();

        do_reset();
        for (int i = 0; i < 85; i++) send_rand(2);
        send_rand(3);
        wait_finish("cap_mid_finish");
        try_load();

        repeat (5) @(negedge clk);
        chk("bits_left", exp_bits.size(), 0);
        chk("writes_left", exp_wa.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
